// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide execute unit.
// Shift-add multiply and restoring divide on operand magnitudes, one radix-2
// step per cycle, with sign fix-up at the end. Divide-by-zero and signed
// overflow bypass the iteration and complete in a single cycle.
`timescale 1ns/1ps
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [4:0]      i_rd,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_rd,
  output logic            o_rd_write_control,
  output logic [XLEN-1:0] o_rd_write_val
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] accHi_q;
  logic [XLEN-1:0] accLo_q;
  logic [XLEN-1:0] opB_q;
  logic [2:0]      funct3_q;
  logic            negRes_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;

  logic            aSigned, bSigned, aNeg, bNeg, negRes_d;
  logic [XLEN-1:0] aMag, bMag;
  logic            divZero, divOverflow, fastPath;
  logic [XLEN-1:0] fastResult;

  // Decode a new request: operand magnitudes, result sign and fast-path result.
  always_comb begin
    aSigned     = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                  (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    bSigned     = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    aNeg        = aSigned && i_rs1_val[XLEN-1];
    bNeg        = bSigned && i_rs2_val[XLEN-1];
    aMag        = aNeg ? -i_rs1_val : i_rs1_val;
    bMag        = bNeg ? -i_rs2_val : i_rs2_val;
    negRes_d    = (i_funct3 == 3'd6) ? aNeg : (aNeg ^ bNeg);
    divZero     = (i_rs2_val == '0);
    divOverflow = i_funct3[2] && !i_funct3[0] &&
                  (i_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (i_rs2_val == '1);
    fastPath    = i_funct3[2] && (divZero || divOverflow);
    if (divZero) begin
      fastResult = i_funct3[1] ? i_rs1_val : '1;
    end else begin
      fastResult = i_funct3[1] ? '0 : i_rs1_val;
    end
  end

  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShifted;
  logic              divGe;
  logic [XLEN-1:0]   divDiff;
  logic [XLEN-1:0]   iterHi, iterLo;
  logic [2*XLEN-1:0] product, productSigned;
  logic [XLEN-1:0]   finalResult;

  // One radix-2 step of the active operation and the sign-corrected result it yields.
  always_comb begin
    mulSum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
    divShifted = {accHi_q, accLo_q[XLEN-1]};
    divGe      = (divShifted >= {1'b0, opB_q});
    divDiff    = divShifted[XLEN-1:0] - opB_q;
    if (funct3_q[2]) begin
      iterHi = divGe ? divDiff : divShifted[XLEN-1:0];
      iterLo = {accLo_q[XLEN-2:0], divGe};
    end else begin
      {iterHi, iterLo} = {mulSum, accLo_q[XLEN-1:1]};
    end
    product       = {iterHi, iterLo};
    productSigned = negRes_q ? -product : product;
    if (funct3_q[2]) begin
      if (funct3_q[1]) begin
        finalResult = negRes_q ? -iterHi : iterHi;
      end else begin
        finalResult = negRes_q ? -iterLo : iterLo;
      end
    end else if (funct3_q[1:0] == 2'd0) begin
      finalResult = productSigned[XLEN-1:0];
    end else begin
      finalResult = productSigned[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and datapath registers: accept, iterate, finish, abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      opB_q    <= '0;
      funct3_q <= '0;
      negRes_q <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        BUSY: begin
          if (i_kill) begin
            state_q <= IDLE;
          end else begin
            accHi_q <= iterHi;
            accLo_q <= iterLo;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(XLEN-1)) begin
              state_q  <= DONE;
              result_q <= finalResult;
            end
          end
        end
        default: begin
          if (i_start && !i_kill) begin
            funct3_q <= i_funct3;
            rd_q     <= i_rd;
            negRes_q <= negRes_d;
            count_q  <= '0;
            accHi_q  <= '0;
            if (i_funct3[2]) begin
              accLo_q <= aMag;
              opB_q   <= bMag;
            end else begin
              accLo_q <= bMag;
              opB_q   <= aMag;
            end
            if (fastPath) begin
              state_q  <= DONE;
              result_q <= fastResult;
            end else begin
              state_q  <= BUSY;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy             = (state_q == BUSY);
  assign o_done             = (state_q == DONE);
  assign o_rd               = rd_q;
  assign o_rd_write_control = (state_q == DONE) && (rd_q != 5'd0);
  assign o_rd_write_val     = result_q;

endmodule

// File: doc/rv32m_muldiv.md
Name: rv32m_muldiv

Overview:
- Iterative RV32M multiply/divide execute unit; consumes operand values read from the register file and produces the write-back triple (rd, write-enable, value) for it.
- Runs alongside the single-cycle ALU and stalls issue via o_busy.
- One radix-2 iteration per cycle.
- Divide-by-zero and signed-overflow cases resolve on a fast path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
i_clk  in  1  single clock, all state on rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_start  in  1  request; accepted only when unit is idle or in its done cycle.
i_kill  in  1  abort in-flight operation (pipeline flush).
i_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
i_rs1_val  in  XLEN  operand A (multiplicand/dividend).
i_rs2_val  in  XLEN  operand B (multiplier/divisor).
i_rd  in  5  destination register index.
o_busy  out  1  operation in progress.
o_done  out  1  one-cycle result-valid pulse.
o_rd  out  5  captured destination index.
o_rd_write_control  out  1  regfile write enable = o_done and (o_rd != 0).
o_rd_write_val  out  XLEN  result; held stable until next accepted start.

Behaviour:
- Reset (i_rst high at an edge): state IDLE.
  - All outputs 0.
  - Counter and internal datapath registers cleared.
  - Applies mid-operation; no o_done for the aborted operation.
- States:
  - IDLE -> BUSY on accepted start (normal case).
  - IDLE -> DONE on accepted start (fast path).
  - BUSY -> DONE after XLEN iterations.
  - DONE -> IDLE, or DONE -> BUSY/DONE if i_start is high in the DONE cycle (back-to-back).
- Start accepted at cycle 0: operands, funct3 and rd captured; later operand changes have no effect.
  - Normal op: o_busy high cycles 1..XLEN, o_done high cycle XLEN+1 (33 by default).
  - Fast path: o_busy stays low, o_done high cycle 1.
- i_start in BUSY: ignored, no queuing.
- i_kill in BUSY: return to IDLE next edge; no o_done; o_rd_write_val keeps its previous value.
  - i_kill in IDLE/DONE has no effect; a start in the same cycle as i_kill is dropped.
- Multiply: shift-add on magnitudes, 2*XLEN product.
  - Sign correction: both signed (MULH), A signed only (MULHSU), none (MUL, MULHU).
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide: restoring shift-subtract on magnitudes.
  - Quotient sign = sign(A) xor sign(B) for DIV.
  - Remainder sign = sign(A) for REM.
  - DIVU/REMU unsigned.
- Fast path (no iterations):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return A.
  - DIV with A = 0x80000000 and B = 0xFFFFFFFF: returns 0x80000000; REM returns 0.
- Multiply never uses the fast path, including zero operands.
- o_rd_write_control never asserts when o_rd = 0; o_done still pulses.

Test Plan:
- Reset then MUL rs1 = 7, rs2 = 0xFFFFFFFD (-3), rd = 5 at cycle 0 -> o_busy cycles 1..32; cycle 33: o_done = 1, o_rd_write_control = 1, o_rd = 5, o_rd_write_val = 0xFFFFFFEB; all low in cycle 34; value held.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each at cycle 33.
- Division (each at cycle 33):
  - DIV -7 (0xFFFFFFF9) / 2 -> 0xFFFFFFFD.
  - REM -7 / 2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path (each at cycle 1, o_busy never high):
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- MUL with rd = 0 -> o_done cycle 33 with o_rd_write_control = 0. Second start in cycle 10 -> ignored. Start in the cycle-33 done cycle -> new result at cycle 66.
- DIV started, i_kill at cycle 12 -> IDLE at cycle 13, no o_done. New DIV started, i_rst at cycle 20 -> all outputs 0 at cycle 21, no o_done ever.
